// File: rtl/mod2243_pkg.sv
// -----------------------------------------------------------------------------
// mod2243_pkg
// Shared constants and types for the mod-2243 multiplier front end.
//   Q          : modulus used for operand pre-reduction (2243)
//   AW         : operand width (12)
//   PW         : product width (23); 2242*2242 = 5026564 < 2^23
//   RUN_CYCLES : number of shift-add iterations (one per operand bit)
//   state_t    : FSM encoding {IDLE, RUN, DONE}
// -----------------------------------------------------------------------------
package mod2243_pkg;

    localparam int Q          = 2243;
    localparam int AW         = 12;
    localparam int PW         = 23;
    localparam int RUN_CYCLES = 12;
    localparam int CW         = 4;

    // Modulus and final iteration index at the widths they are compared against.
    localparam logic [AW-1:0] Q_W      = AW'(Q);
    localparam logic [CW-1:0] LAST_CNT = CW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cond_sub_2243.sv
// -----------------------------------------------------------------------------
// cond_sub_2243
// Single conditional subtract that maps any 12-bit value into [0, Q-1].
// One subtraction suffices because 4095 - 2243 = 1852 < Q.
//   i_x : AW-bit input, any value
//   o_y : AW-bit output, i_x >= Q ? i_x - Q : i_x
// -----------------------------------------------------------------------------
module cond_sub_2243
    import mod2243_pkg::*;
(
    input  logic [AW-1:0] i_x,
    output logic [AW-1:0] o_y
);

    logic w_ge;

    assign w_ge = (i_x >= Q_W);
    assign o_y  = w_ge ? (i_x - Q_W) : i_x;

endmodule

// File: rtl/serial_modmul_2243_front.sv
// -----------------------------------------------------------------------------
// serial_modmul_2243_front
// Constant-time shift-add multiplier feeding the mod-2243 Barrett reducer.
// Operands are pre-reduced into [0, Q-1] at capture, then multiplied over
// exactly RUN_CYCLES iterations regardless of operand values.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operand pair valid
//   in_ready  : operands accepted this cycle (IDLE, or DONE while out_ready)
//   a, b      : AW-bit operands, any value
//   out_valid : out_prod valid
//   out_ready : downstream accepts out_prod
//   out_prod  : PW-bit product a' * b', held until the next result is ready
// -----------------------------------------------------------------------------
module serial_modmul_2243_front
    import mod2243_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_prod
);

    state_t        r_state;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_prod;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_a;
    logic [AW-1:0] r_b;
    logic          r_out_valid;

    logic [AW-1:0] w_a_red;
    logic [AW-1:0] w_b_red;
    logic [PW-1:0] w_addend;
    logic [PW-1:0] w_acc_next;
    logic          w_in_ready;
    logic          w_accept;

    cond_sub_2243 u_sub_a (
        .i_x (a),
        .o_y (w_a_red)
    );

    cond_sub_2243 u_sub_b (
        .i_x (b),
        .o_y (w_b_red)
    );

    // Partial product for the current multiplier bit. r_b is shifted right each
    // iteration, so bit 0 always holds the bit matching weight 2^r_cnt.
    assign w_addend   = r_b[0] ? ({{(PW-AW){1'b0}}, r_a} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;

    // NOTE: a default assignment before the case keeps every path driven, so no
    // latch is inferred for states that do not mention the signal.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            DONE:    w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a_red;
                        r_b     <= w_b_red;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    // No early exit when r_b reaches zero: latency must not
                    // depend on operand values.
                    r_acc <= w_acc_next;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_prod      <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    // w_accept here equals in_valid & out_ready, so a new pair
                    // is captured on the same edge the result is consumed.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_a     <= w_a_red;
                            r_b     <= w_b_red;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_prod  = r_prod;

endmodule

// File: tb/tb_serial_modmul_2243_front.sv
// -----------------------------------------------------------------------------
// tb_serial_modmul_2243_front
// Directed and randomized checks of serial_modmul_2243_front against a plain
// arithmetic reference: expected product = (a mod 2243) * (b mod 2243).
// -----------------------------------------------------------------------------
module tb_serial_modmul_2243_front;

    localparam int QM        = 2243;
    localparam int SOAK_N    = 400;
    localparam int SOAK_MAXC = 30000;
    localparam int LAT       = 13;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_prod;

    int n_checks = 0;
    int n_errors = 0;

    serial_modmul_2243_front dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reduce each operand modulo Q, multiply as integers.
    function automatic int ref_prod(input int av, input int bv);
        return (av % QM) * (bv % QM);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting edge; counts edges until out_valid.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Accept one pair from IDLE with out_ready high, check latency and product,
    // then let the result be consumed.
    task automatic run_one(input string tag, input int av, input int bv, input int exp);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 12'(av);
        b         = 12'(bv);
        #1;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        // Scramble operands after capture; they must have no effect.
        a = 12'($urandom);
        b = 12'($urandom);
        wait_done(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_prod"}, int'(out_prod), exp);
        tick();
        check({tag, "_valid_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int lat;
        int stale;
        int n_acc;
        int n_out;
        int cyc;
        int exp_q[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #3;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_prod", int'(out_prod), 0);
        check("reset_in_ready", int'(in_ready), 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Largest reduced operands; downstream reduction of 2242^2 is 1.
        run_one("max_red", 2242, 2242, 5026564);
        check("max_red_barrett", int'(out_prod) % QM, 1);

        run_one("a4095_b1", 4095, 1, 1852);
        run_one("q_q", 2243, 2243, 0);
        run_one("zero_a", 0, 1234, 0);

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 12'd100;
        b         = 12'd200;
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check("bp_latency", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_prod", int'(out_prod), 20000);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_in_ready", int'(in_ready), 0);
            tick();
        end
        // Release with a new pair waiting: both handshakes on the same edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 12'd3;
        b         = 12'd5;
        #1;
        check("b2b_in_ready", int'(in_ready), 1);
        check("b2b_prev_prod", int'(out_prod), 20000);
        tick();
        in_valid = 1'b0;
        check("b2b_valid_drop", int'(out_valid), 0);
        wait_done(lat);
        check("b2b_latency", lat, LAT);
        check("b2b_prod", int'(out_prod), 15);
        tick();

        // Reset in the middle of RUN.
        in_valid = 1'b1;
        a        = 12'd7;
        b        = 12'd9;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_prod", int'(out_prod), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);
        run_one("after_rst", 7, 9, 63);

        // Random soak with random valid/ready gaps; results must come back in
        // acceptance order, none dropped or duplicated.
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        while ((n_acc < SOAK_N || exp_q.size() != 0) && cyc < SOAK_MAXC) begin
            in_valid  = (n_acc < SOAK_N) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a         = 12'($urandom);
            b         = 12'($urandom);
            #3;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_prod(int'(a), int'(b)));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("soak_extra_out", int'(out_valid), 0);
                end else begin
                    check("soak_prod", int'(out_prod), exp_q.pop_front());
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("soak_out_count", n_out, SOAK_N);
        check("soak_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
